// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with IDLE/RUN/HALT control, branch redirect/squash, stall hold and saturating redirect counter
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  input  logic        start_pi,
  input  logic        stall_pi,
  input  logic        halt_pi,
  input  logic        is_branch_taken_pi,
  input  logic [15:0] branch_target_pi,
  input  logic [15:0] instr_mem_data_pi,
  output logic [15:0] pc_po,
  output logic [15:0] if_instr_po,
  output logic [15:0] if_pc_po,
  output logic        if_valid_po,
  output logic        halted_po,
  output logic [15:0] branch_count_po
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, instr_q, instr_d, ifpc_q, ifpc_d, bcnt_q, bcnt_d;
  logic        valid_q, valid_d;
  // next state: in RUN halt beats branch beats stall beats normal advance
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    bcnt_d  = bcnt_q;
    if (state_q == IDLE) begin
      pc_d    = RESET_PC;
      valid_d = 1'b0;
      state_d = start_pi ? RUN : IDLE;
    end else if (state_q == RUN) begin
      if (halt_pi) begin
        state_d = HALT;
        valid_d = 1'b0;
      end else if (is_branch_taken_pi) begin
        pc_d    = branch_target_pi;
        valid_d = 1'b0;
        bcnt_d  = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;
      end else if (!stall_pi) begin
        instr_d = instr_mem_data_pi;
        ifpc_d  = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 16'd1;
      end
    end else begin
      valid_d = 1'b0;
    end
  end
  // state registers with reset overriding every other input
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      ifpc_q  <= 16'h0000;
      valid_q <= 1'b0;
      bcnt_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      bcnt_q  <= bcnt_d;
    end
  end
  assign pc_po           = pc_q;
  assign if_instr_po     = instr_q;
  assign if_pc_po        = ifpc_q;
  assign if_valid_po     = valid_q;
  assign halted_po       = (state_q == HALT);
  assign branch_count_po = bcnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a behavioural fetch model, checked every cycle
module tb_fetch_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0, halt = 1'b0, br = 1'b0;
  logic [15:0] tgt = 16'h0000;
  logic [15:0] mem, pc, ins, ifpc, bcnt;
  logic        valid, halted;
  int          pass_n = 0, total_n = 0;
  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk_pi(clk), .reset_pi(reset), .start_pi(start), .stall_pi(stall), .halt_pi(halt),
    .is_branch_taken_pi(br), .branch_target_pi(tgt), .instr_mem_data_pi(mem),
    .pc_po(pc), .if_instr_po(ins), .if_pc_po(ifpc), .if_valid_po(valid),
    .halted_po(halted), .branch_count_po(bcnt)
  );
  assign mem = pc ^ 16'hA5A5;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  int          m_mode;
  logic        armed = 1'b0, m_valid;
  logic [15:0] m_pc, m_ins, m_ifpc, m_cnt;
  // reference: 0 = idle, 1 = running, 2 = halted; memory word at address a is a^A5A5
  always @(posedge clk) begin
    if (reset) begin
      armed <= 1'b1; m_mode <= 0; m_pc <= 16'h0000; m_ins <= 16'h0000;
      m_ifpc <= 16'h0000; m_valid <= 1'b0; m_cnt <= 16'h0000;
    end else if (m_mode == 0) begin
      if (start) m_mode <= 1;
    end else if (m_mode == 1) begin
      if (halt) begin
        m_mode <= 2; m_valid <= 1'b0;
      end else if (br) begin
        m_pc <= tgt; m_valid <= 1'b0;
        if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      end else if (!stall) begin
        m_ins <= m_pc ^ 16'hA5A5; m_ifpc <= m_pc; m_valid <= 1'b1; m_pc <= m_pc + 16'd1;
      end
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("model_pc", pc, m_pc);
      chk("model_instr", ins, m_ins);
      chk("model_ifpc", ifpc, m_ifpc);
      chk("model_valid", {15'b0, valid}, {15'b0, m_valid});
      chk("model_halted", {15'b0, halted}, {15'b0, m_mode == 2});
      chk("model_bcnt", bcnt, m_cnt);
    end
  end
  initial begin
    tick; tick; reset = 1'b0;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_valid", {15'b0, valid}, 16'h0000);
    chk("rst_instr", ins, 16'h0000);
    chk("rst_ifpc", ifpc, 16'h0000);
    chk("rst_halted", {15'b0, halted}, 16'h0000);
    chk("rst_bcnt", bcnt, 16'h0000);
    tick;
    chk("idle_pc", pc, 16'h0000);
    start = 1'b1; tick; start = 1'b0;
    chk("start_valid", {15'b0, valid}, 16'h0000);
    tick;
    chk("first_valid", {15'b0, valid}, 16'h0001);
    chk("first_ifpc", ifpc, 16'h0000);
    chk("first_instr", ins, 16'hA5A5);
    tick;
    chk("second_ifpc", ifpc, 16'h0001);
    chk("second_instr", ins, 16'hA5A4);
    tick; tick; tick;
    chk("pc5", pc, 16'h0005);
    br = 1'b1; tgt = 16'h0040; tick; br = 1'b0;
    chk("br_valid", {15'b0, valid}, 16'h0000);
    chk("br_pc", pc, 16'h0040);
    chk("br_cnt", bcnt, 16'h0001);
    chk("br_ifpc_hold", ifpc, 16'h0004);
    tick;
    chk("br_tgt_ifpc", ifpc, 16'h0040);
    chk("br_tgt_valid", {15'b0, valid}, 16'h0001);
    chk("br_tgt_instr", ins, 16'hA5E5);
    br = 1'b1; tgt = 16'h0006; tick; br = 1'b0; tick;
    chk("pc7", pc, 16'h0007);
    stall = 1'b1;
    repeat (3) begin
      tick;
      chk("stall_pc", pc, 16'h0007);
      chk("stall_ifpc", ifpc, 16'h0006);
      chk("stall_valid", {15'b0, valid}, 16'h0001);
    end
    stall = 1'b0; tick;
    chk("resume_ifpc", ifpc, 16'h0007);
    chk("resume_instr", ins, 16'hA5A2);
    stall = 1'b1; br = 1'b1; tgt = 16'h0100; tick; stall = 1'b0; br = 1'b0;
    chk("stallbr_pc", pc, 16'h0100);
    chk("stallbr_valid", {15'b0, valid}, 16'h0000);
    chk("stallbr_cnt", bcnt, 16'h0003);
    br = 1'b1; tgt = 16'hFFFE; tick; br = 1'b0;
    tick; chk("wrap_fffe", ifpc, 16'hFFFE);
    tick; chk("wrap_ffff", ifpc, 16'hFFFF);
    tick; chk("wrap_0000", ifpc, 16'h0000);
    chk("wrap_pc", pc, 16'h0001);
    halt = 1'b1; br = 1'b1; tgt = 16'h1234; tick; halt = 1'b0;
    chk("halt_flag", {15'b0, halted}, 16'h0001);
    chk("halt_pc", pc, 16'h0001);
    chk("halt_cnt", bcnt, 16'h0004);
    chk("halt_valid", {15'b0, valid}, 16'h0000);
    repeat (4) tick;
    br = 1'b0;
    chk("halted_pc", pc, 16'h0001);
    chk("halted_cnt", bcnt, 16'h0004);
    chk("halted_stay", {15'b0, halted}, 16'h0001);
    reset = 1'b1; tick; reset = 1'b0;
    start = 1'b1; tick; start = 1'b0; tick; tick;
    repeat (3) begin
      br = 1'b1; tgt = 16'($urandom); tick; br = 1'b0; tick;
    end
    chk("pre_rst_cnt", bcnt, 16'h0003);
    reset = 1'b1; tick; reset = 1'b0;
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_valid", {15'b0, valid}, 16'h0000);
    chk("mid_rst_instr", ins, 16'h0000);
    chk("mid_rst_ifpc", ifpc, 16'h0000);
    chk("mid_rst_cnt", bcnt, 16'h0000);
    stall = 1'b1; br = 1'b1; tgt = 16'h5555;
    repeat (3) tick;
    chk("idle_hold_pc", pc, 16'h0000);
    chk("idle_hold_valid", {15'b0, valid}, 16'h0000);
    chk("idle_hold_cnt", bcnt, 16'h0000);
    stall = 1'b0; br = 1'b0;
    repeat (3000) begin
      reset = ($urandom_range(63) == 0);
      start = ($urandom_range(3) == 0);
      halt  = ($urandom_range(39) == 0);
      stall = ($urandom_range(3) == 0);
      br    = ($urandom_range(4) == 0);
      tgt   = ($urandom_range(3) == 0) ? 16'hFFFC + 16'($urandom_range(3)) : 16'($urandom);
      tick;
    end
    reset = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0; br = 1'b0; tick; reset = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    br = 1'b1; tgt = 16'h0000;
    repeat (65540) tick;
    br = 1'b0;
    chk("sat_cnt", bcnt, 16'hFFFF);
    tick;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset and held in IDLE.
REQ-002 The block SHALL have port clk_pi, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset_pi, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start_pi, input, 1, which leaves IDLE and begins fetching.
REQ-005 The block SHALL have port stall_pi, input, 1, the decode-stage hold request.
REQ-006 The block SHALL have port halt_pi, input, 1, the halt request from decode.
REQ-007 The block SHALL have port is_branch_taken_pi, input, 1, the branch-comparator decision.
REQ-008 The block SHALL have port branch_target_pi, input, 16, the redirect address, valid when is_branch_taken_pi=1.
REQ-009 The block SHALL have port instr_mem_data_pi, input, 16, the combinational instruction-memory read data at pc_po.
REQ-010 The block SHALL have port pc_po, output, 16, the current fetch address driven to instruction memory.
REQ-011 The block SHALL have port if_instr_po, output, 16, the registered IF/ID instruction.
REQ-012 The block SHALL have port if_pc_po, output, 16, the registered address of if_instr_po.
REQ-013 The block SHALL have port if_valid_po, output, 1, which is 1 when the IF/ID register holds a real instruction.
REQ-014 The block SHALL have port halted_po, output, 1, which is 1 while in HALT.
REQ-015 The block SHALL have port branch_count_po, output, 16, the count of taken redirects.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and HALT, with state visible only via halted_po and if_valid_po.
REQ-017 IDLE SHALL go to RUN on the edge where start_pi=1; otherwise it holds IDLE with pc_po=RESET_PC and if_valid_po=0.
REQ-018 RUN SHALL go to HALT on the edge where halt_pi=1; HALT SHALL be exited only by reset_pi.
REQ-019 In RUN, edge priority SHALL be halt_pi > is_branch_taken_pi > stall_pi > normal advance.
REQ-020 Normal advance in RUN SHALL be: if_instr_po<=instr_mem_data_pi, if_pc_po<=pc_po, if_valid_po<=1, pc_po<=pc_po+1 with modulo-2^16 wrap (16'hFFFF -> 16'h0000).
REQ-021 A taken branch in RUN SHALL set pc_po<=branch_target_pi and if_valid_po<=0 (squash), and increment branch_count_po; if_instr_po and if_pc_po hold.
REQ-022 A taken branch SHALL override a simultaneous stall_pi=1 (redirect and squash still occur).
REQ-023 A stall in RUN (no branch, no halt) SHALL hold pc_po, if_instr_po, if_pc_po and if_valid_po unchanged.
REQ-024 A halt in RUN SHALL hold pc_po, set if_valid_po<=0 and halted_po<=1, and ignore a simultaneous branch (no redirect, no count).
REQ-025 Branch and stall inputs SHALL be ignored in IDLE and HALT; if_valid_po SHALL be 0 in both states.
REQ-026 branch_count_po SHALL saturate at 16'hFFFF.
REQ-027 The redirect penalty SHALL be exactly one squashed slot: the first valid instruction after a redirect has if_pc_po=branch_target_pi and appears two edges after the branch edge.
REQ-028 The first valid instruction after start SHALL appear two edges after the start edge, with if_pc_po=RESET_PC.

Reset
REQ-029 On a reset_pi=1 edge, the block SHALL set state=IDLE, pc_po=RESET_PC, if_instr_po=16'h0000, if_pc_po=16'h0000, if_valid_po=0, halted_po=0 and branch_count_po=0, overriding all other inputs.
REQ-030 A reset asserted mid-RUN or in HALT SHALL take effect on that same edge with no partial update, and all outputs SHALL be stable until the next edge.

Verification
REQ-031 The bench SHALL cover: reset, start=1 for 1 cycle, memory returns addr^16'hA5A5 -> if_valid_po=1 from the 2nd edge with if_pc_po=0,1,2,... and matching instructions.
REQ-032 The bench SHALL cover: branch_taken=1 with target 16'h0040 at pc=5 -> next if_valid_po=0, pc_po=0x40, following edge if_pc_po=0x40, and branch_count_po=1.
REQ-033 The bench SHALL cover: stall=1 for 3 cycles at pc=7 -> all outputs frozen, then resume at if_pc_po=7; a branch asserted during the stall redirects anyway.
REQ-034 The bench SHALL cover: branch target 16'hFFFE, no stalls -> if_pc_po sequence FFFE, FFFF, 0000.
REQ-035 The bench SHALL cover: halt_pi=1 together with branch_taken=1 -> halted_po=1, pc held, branch_count_po unchanged, and later branches ignored until reset.
REQ-036 The bench SHALL cover: reset asserted mid-RUN after 3 branches -> all outputs return to their reset values on that edge, and IDLE holds until start_pi.
